// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line-level constants for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - byte hand-off between the deserializer and the frame Receiver
interface uart_rx_deserializer_if #(
    parameter int WORD_LENGTH = 8
);

    logic                   clearInterrupt;
    logic [WORD_LENGTH-1:0] Data_w;
    logic                   interrupt_bit;
    logic                   framing_error;
    logic                   overrun;

    modport master (
        input  clearInterrupt,
        output Data_w,
        output interrupt_bit,
        output framing_error,
        output overrun
    );

    modport slave (
        output clearInterrupt,
        input  Data_w,
        input  interrupt_bit,
        input  framing_error,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_deserializer_sync.sv
// rtl/uart_rx_deserializer_sync.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 LSB-first serial receiver with sticky byte/error flags
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int BAUD_DIV    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          SerialDataRx,
    uart_rx_deserializer_if.master        rx_bus
);

    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int IDX_W    = $clog2(WORD_LENGTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_LENGTH - 1);

    logic                   rx_s;
    rx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WORD_LENGTH-1:0] shift_q;
    logic [WORD_LENGTH-1:0] data_q;
    logic                   irq_q;
    logic                   fe_q;
    logic                   ovr_q;

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (SerialDataRx),
        .q_o   (rx_s)
    );

    // Acknowledge clears first; a completion on the same edge then overrides the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            irq_q   <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (rx_bus.clearInterrupt) begin
                irq_q <= 1'b0;
                fe_q  <= 1'b0;
                ovr_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s == START_BIT) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[WORD_LENGTH-1:1]};
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    // Returning to IDLE at the stop-bit mid-point keeps back-to-back frames aligned.
                    if (cnt_q == BAUD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s == STOP_BIT) begin
                            data_q <= shift_q;
                            irq_q  <= 1'b1;
                            if (irq_q && !rx_bus.clearInterrupt) begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            fe_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rx_bus.Data_w        = data_q;
    assign rx_bus.interrupt_bit = irq_q;
    assign rx_bus.framing_error = fe_q;
    assign rx_bus.overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

    localparam int WL = 8;
    localparam int BD = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rx_pin = 1'b1;

    uart_rx_deserializer_if #(.WORD_LENGTH(WL)) bus ();

    uart_rx_deserializer #(
        .WORD_LENGTH (WL),
        .BAUD_DIV    (BD)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .SerialDataRx (rx_pin),
        .rx_bus       (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int t_fall   = 0;

    logic [7:0] t2_bytes [5];
    bit         t1_found, t2_found, t5_found;
    int         t1_lat, t2_lat, t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a negedge; returns on a negedge so frames can be chained gap-free.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                rx_pin = 1'b0;
                t_fall = cyc;
            end else if (i == 9) begin
                rx_pin = stop_lvl;
            end else begin
                rx_pin = d[i-1];
            end
            repeat (BD) @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic wait_irq(output bit found, output int lat);
        found = 1'b0;
        lat   = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.interrupt_bit === 1'b1) begin
                found = 1'b1;
                lat   = cyc - t_fall;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        bus.clearInterrupt = 1'b1;
        @(negedge clk);
        bus.clearInterrupt = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic irq, input logic fe, input logic ovr);
        check({tag, "_irq"}, 32'(bus.interrupt_bit), 32'(irq));
        check({tag, "_fe"},  32'(bus.framing_error), 32'(fe));
        check({tag, "_ovr"}, 32'(bus.overrun),       32'(ovr));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        t2_bytes[0] = 8'hFE;
        t2_bytes[1] = 8'h03;
        t2_bytes[2] = 8'h01;
        t2_bytes[3] = 8'h03;
        t2_bytes[4] = 8'hEF;
        bus.clearInterrupt = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_data", 32'(bus.Data_w), 32'h0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // single byte with latency measurement
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_irq(t1_found, t1_lat);
                check("t1_irq_seen", 32'(t1_found), 32'h1);
                check("t1_latency_window", 32'(t1_lat >= 154 && t1_lat <= 156), 32'h1);
                check("t1_data", 32'(bus.Data_w), 32'h55);
                check_flags("t1", 1'b1, 1'b0, 1'b0);
            end
        join
        pulse_clear();
        check("t1_cleared_irq", 32'(bus.interrupt_bit), 32'h0);
        idle(5);

        // back-to-back frames, acknowledged two cycles after each interrupt
        fork
            begin
                for (int i = 0; i < 5; i++) send_frame(t2_bytes[i], 1'b1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    wait_irq(t2_found, t2_lat);
                    check($sformatf("t2_irq_seen_%0d", i), 32'(t2_found), 32'h1);
                    check($sformatf("t2_data_%0d", i), 32'(bus.Data_w), 32'(t2_bytes[i]));
                    check($sformatf("t2_ovr_%0d", i), 32'(bus.overrun), 32'h0);
                    idle(2);
                    pulse_clear();
                end
            end
        join
        idle(5);

        // short low glitch must not start a frame
        rx_pin = 1'b0;
        idle(4);
        rx_pin = 1'b1;
        idle(30);
        check_flags("t3_glitch", 1'b0, 1'b0, 1'b0);
        send_frame(8'h0B, 1'b1);
        idle(2);
        check("t3_data", 32'(bus.Data_w), 32'h0B);
        check_flags("t3_after", 1'b1, 1'b0, 1'b0);
        pulse_clear();
        idle(3);

        // bad stop bit
        send_frame(8'hA5, 1'b0);
        idle(20);
        check("t4_data_held", 32'(bus.Data_w), 32'h0B);
        check_flags("t4_fe", 1'b0, 1'b1, 1'b0);
        pulse_clear();
        check_flags("t4_cleared", 1'b0, 1'b0, 1'b0);
        idle(3);

        // overrun without acknowledge
        send_frame(8'h04, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(2);
        check("t5a_data", 32'(bus.Data_w), 32'h00);
        check_flags("t5a", 1'b1, 1'b0, 1'b1);
        pulse_clear();
        check_flags("t5a_cleared", 1'b0, 1'b0, 1'b0);
        idle(3);

        // acknowledge on the very edge the second byte completes
        t0 = cyc;
        fork
            begin
                send_frame(8'h04, 1'b1);
                send_frame(8'h00, 1'b1);
            end
            begin
                t5_found = 1'b0;
                for (int k = 0; k < 400; k++) begin
                    if (cyc == t0 + 314) begin
                        t5_found = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                if (t5_found) pulse_clear();
            end
        join
        check("t5b_clear_timed", 32'(t5_found), 32'h1);
        check("t5b_data", 32'(bus.Data_w), 32'h00);
        check_flags("t5b", 1'b1, 1'b0, 1'b0);

        // leave an unacknowledged byte pending so reset has state to clear
        send_frame(8'h3C, 1'b1);
        idle(2);
        check("t6_pre_data", 32'(bus.Data_w), 32'h3C);
        check_flags("t6_pre", 1'b1, 1'b0, 1'b1);

        // reset asserted during data bit 4 of 0xEF
        fork
            send_frame(8'hEF, 1'b1);
            begin
                idle(88);
                rst_n = 1'b0;
                @(negedge clk);
                check("t6_rst_data", 32'(bus.Data_w), 32'h0);
                check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
            end
        join
        rst_n = 1'b1;
        idle(5);
        check_flags("t6_idle", 1'b0, 1'b0, 1'b0);
        send_frame(8'hFE, 1'b1);
        idle(2);
        check("t6_data", 32'(bus.Data_w), 32'hFE);
        check_flags("t6_after", 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
